hue_wheel_sequencer: RTL

- Controller that sequences a full RGB hue wheel from one shared timebase. It replaces three free-running, phase-offset single-channel fade generators.
- Runs a 6-sector colour FSM, a step scheduler and a shared PWM period counter.
- Produces per-channel duty values and glitch-free PWM drive for the board RGB LED.
- Sits between the clock/reset and the top-level LED pins. The top level applies any pin inversion.

---
 rtl/hue_wheel_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/hue_wheel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hue_wheel_sequencer
// Brief    : 6-sector RGB hue wheel with a shared step timebase and a PWM
//            timebase. Duty registers update only at PWM period boundaries.
// Revision : 1.0
// ============================================================================
module hue_wheel_sequencer #(
  parameter  int TICK_INTERVAL    = 12000,
  parameter  int STEPS_PER_SECTOR = 167,
  parameter  int PWM_INTERVAL     = 1200,
  parameter  int STEP_VAL         = PWM_INTERVAL / STEPS_PER_SECTOR,
  localparam int DW               = $clog2(PWM_INTERVAL) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          restart,
  output logic [2:0]    sector,
  output logic          sector_done,
  output logic [DW-1:0] duty_r,
  output logic [DW-1:0] duty_g,
  output logic [DW-1:0] duty_b,
  output logic          led_r,
  output logic          led_g,
  output logic          led_b
);

  localparam int TW = (TICK_INTERVAL > 1) ? $clog2(TICK_INTERVAL) : 1;
  localparam int SW = (STEPS_PER_SECTOR > 1) ? $clog2(STEPS_PER_SECTOR) : 1;
  localparam int PW = $clog2(PWM_INTERVAL);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_INTERVAL - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEPS_PER_SECTOR - 1);
  localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_INTERVAL - 1);
  localparam logic [DW-1:0] DUTY_FULL = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] DUTY_STEP = DW'(STEP_VAL);

  typedef enum logic [2:0] {
    SEC_0 = 3'd0,
    SEC_1 = 3'd1,
    SEC_2 = 3'd2,
    SEC_3 = 3'd3,
    SEC_4 = 3'd4,
    SEC_5 = 3'd5
  } sector_t;

  sector_t       sector_q, sector_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [PW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic          sector_done_q, sector_done_d;
  logic [DW-1:0] duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
  logic          led_r_q, led_r_d, led_g_q, led_g_d, led_b_q, led_b_d;

  logic          tick;
  logic          pwm_wrap;
  logic [DW-1:0] ramp_up, ramp_down;
  logic [DW-1:0] tgt_r, tgt_g, tgt_b;

  // Wheel state: restart wins over everything, en=0 freezes the wheel.
  always_comb begin
    tick          = en && (tick_cnt_q == TICK_LAST);
    tick_cnt_d    = tick_cnt_q;
    step_cnt_d    = step_cnt_q;
    sector_d      = sector_q;
    sector_done_d = 1'b0;
    if (restart) begin
      tick_cnt_d = '0;
      step_cnt_d = '0;
      sector_d   = SEC_0;
    end else if (en) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      if (tick) begin
        if (step_cnt_q == STEP_LAST) begin
          step_cnt_d    = '0;
          sector_done_d = 1'b1;
          case (sector_q)
            SEC_0:   sector_d = SEC_1;
            SEC_1:   sector_d = SEC_2;
            SEC_2:   sector_d = SEC_3;
            SEC_3:   sector_d = SEC_4;
            SEC_4:   sector_d = SEC_5;
            default: sector_d = SEC_0;
          endcase
        end else begin
          step_cnt_d = step_cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ramp_up   = DW'(step_cnt_q) * DUTY_STEP;
    ramp_down = DUTY_FULL - ramp_up;
    tgt_r     = DUTY_FULL;
    tgt_g     = '0;
    tgt_b     = '0;
    case (sector_q)
      SEC_0:   begin tgt_r = DUTY_FULL; tgt_g = ramp_up;   tgt_b = '0;        end
      SEC_1:   begin tgt_r = ramp_down; tgt_g = DUTY_FULL; tgt_b = '0;        end
      SEC_2:   begin tgt_r = '0;        tgt_g = DUTY_FULL; tgt_b = ramp_up;   end
      SEC_3:   begin tgt_r = '0;        tgt_g = ramp_down; tgt_b = DUTY_FULL; end
      SEC_4:   begin tgt_r = ramp_up;   tgt_g = '0;        tgt_b = DUTY_FULL; end
      default: begin tgt_r = DUTY_FULL; tgt_g = '0;        tgt_b = ramp_down; end
    endcase
  end

  // Duty is shadowed into the live registers only on the last PWM count,
  // so a period never sees two different duty values.
  always_comb begin
    pwm_wrap  = (pwm_cnt_q == PWM_LAST);
    pwm_cnt_d = pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
    duty_r_d  = pwm_wrap ? tgt_r : duty_r_q;
    duty_g_d  = pwm_wrap ? tgt_g : duty_g_q;
    duty_b_d  = pwm_wrap ? tgt_b : duty_b_q;
    led_r_d   = DW'(pwm_cnt_q) < duty_r_q;
    led_g_d   = DW'(pwm_cnt_q) < duty_g_q;
    led_b_d   = DW'(pwm_cnt_q) < duty_b_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q    <= '0;
      step_cnt_q    <= '0;
      sector_q      <= SEC_0;
      sector_done_q <= 1'b0;
      pwm_cnt_q     <= '0;
      duty_r_q      <= DUTY_FULL;
      duty_g_q      <= '0;
      duty_b_q      <= '0;
      led_r_q       <= 1'b0;
      led_g_q       <= 1'b0;
      led_b_q       <= 1'b0;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      step_cnt_q    <= step_cnt_d;
      sector_q      <= sector_d;
      sector_done_q <= sector_done_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_r_q      <= duty_r_d;
      duty_g_q      <= duty_g_d;
      duty_b_q      <= duty_b_d;
      led_r_q       <= led_r_d;
      led_g_q       <= led_g_d;
      led_b_q       <= led_b_d;
    end
  end

  assign sector      = sector_q;
  assign sector_done = sector_done_q;
  assign duty_r      = duty_r_q;
  assign duty_g      = duty_g_q;
  assign duty_b      = duty_b_q;
  assign led_r       = led_r_q;
  assign led_g       = led_g_q;
  assign led_b       = led_b_q;

endmodule
`default_nettype wire
